ft1248_device_responder: RTL and testbench
==========================================

Name: ft1248_device_responder

Overview:
- Synthesisable device-side (FTDI-end) responder for the FT1248 link driven by the SoCDebug FT1248 master.
- Decodes master command/data bit-streams and returns ACK/NAK and read data.
- Exchanges whole bytes with local logic over two valid/ready streams.
- Used for FPGA loopback, emulation and SoC-level verification of the debug path without an FTDI part.

Parameters:
- FT1248_WIDTH, 1, MIOSIO bus width in bits; legal values 1, 2, 4. Bits per FT clock = FT1248_WIDTH; beats per byte = 8/FT1248_WIDTH.

Ports:
- HCLK  input  1  system clock; all logic on rising edge
- HRESETn  input  1  synchronous active-low reset
- FT_CLK_I  input  1  SCLK from master; synchronised internally
- FT_SSN_I  input  1  SS_N from master, active low
- FT_MISO_O  output  1  MISO to master: status when idle, ACK/NAK in turnaround
- FT_MIOSIO_I  input  FT1248_WIDTH  MIOSIO from master
- FT_MIOSIO_O  output  FT1248_WIDTH  MIOSIO driven by device during read data
- FT_MIOSIO_E  output  FT1248_WIDTH  MIOSIO output enable, active high
- RXD_DATA  output  8  byte written by master
- RXD_VALID  output  1  RXD_DATA valid
- RXD_READY  input  1  local sink accepts RXD_DATA
- TXD_DATA  input  8  byte for master to read
- TXD_VALID  input  1  TXD_DATA valid
- TXD_READY  output  1  pop pulse: TXD byte consumed

Behaviour:
- Reset (HRESETn low at HCLK edge):
  - State IDLE; FT_MISO_O=1; FT_MIOSIO_O=0; FT_MIOSIO_E=0; RXD_VALID=0; RXD_DATA=0; TXD_READY=0.
  - Synchroniser flops cleared (CLK low, SSN high).
  - Reset mid-transaction discards partial byte; no stream handshake is issued.
- Input synchronisation:
  - FT_CLK_I, FT_SSN_I and FT_MIOSIO_I each pass through 2 HCLK flops.
  - Rise/fall of CLK and fall/rise of SSN are detected on the synchronised values.
  - Master FT clock high and low phases must each be ≥4 HCLK (CLKDIV ≥ 3).
- Outputs change exactly 1 HCLK after a detected edge, i.e. ≤3 HCLK after the pin edge.
- Idle status (IDLE state): FT_MISO_O = ~TXD_VALID (low = read data available); FT_MIOSIO_E=0.
- IDLE -> CMD on detected SSN fall. Bit counter cleared.
- CMD:
  - On each CLK rise, shift in FT1248_WIDTH bits, MSB-first, into an 8-bit command register.
  - After 8/FT1248_WIDTH rises go to TA.
- TA (turnaround): on the next CLK fall, drive FT_MISO_O:
  - CMD_WRITE with RXD_VALID==0: ACK (0) -> WDATA.
  - CMD_READ with TXD_VALID==1: ACK (0); latch TXD_DATA into the shift register -> RDATA, with FT_MIOSIO_E all-ones and the first MSB beat on FT_MIOSIO_O.
  - Any other command, or resource not ready: NAK (1) -> DONE.
- WDATA:
  - Shift MIOSIO on each CLK rise, MSB-first.
  - On the final beat, load RXD_DATA and set RXD_VALID=1 in the same HCLK.
  - -> DONE.
- RXD_VALID clears on the HCLK where RXD_VALID && RXD_READY. RXD_DATA is stable while RXD_VALID=1.
- RDATA:
  - Present the next beat on each CLK fall.
  - On the CLK rise that completes the final beat, pulse TXD_READY for 1 HCLK (pop).
  - -> DONE with FT_MIOSIO_E=0.
- DONE: ignore CLK; on SSN rise -> IDLE.
- SSN rise in any non-IDLE state:
  - -> IDLE next HCLK; FT_MIOSIO_E=0.
  - Partial write discarded (RXD_VALID unchanged); partial read not popped (TXD_READY stays 0).
- SSN fall while in IDLE coincident with a CLK edge: the CLK edge is ignored.
- One byte per SSN-low transaction. Extra CLK edges in DONE are ignored.
- Bit counter width is 3 bits; it never wraps within a byte because termination is by exact beat count.

Decomposition:
- Shared package ft1248_pkg:
  - state encoding (IDLE, CMD, TA, WDATA, RDATA, DONE)
  - CMD_WRITE = 8'h00, CMD_READ = 8'h01
  - ACK = 1'b0, NAK = 1'b1
  - min FT clock phase constant (4)
- One sub-module: ft1248_edge_sync, containing the 2-flop synchronisers and the CLK/SSN edge detectors. The package is shared with the SoCDebug master.

Test Plan:
- Write, WIDTH=1: SSN low, cmd 8'h00, data 8'hA5 (8 beats) -> ACK on MISO; RXD_DATA=8'hA5, RXD_VALID=1 until RXD_READY; MISO idles 1 after SSN high.
- Read, WIDTH=4: TXD_DATA=8'h3C, TXD_VALID=1; idle MISO=0; cmd 8'h01 (2 beats) -> ACK; MIOSIO beats 4'h3 then 4'hC, E=4'hF; single 1-HCLK TXD_READY pulse.
- NAK cases:
  - cmd 8'h00 while RXD_VALID=1 -> MISO=1, RXD_DATA unchanged.
  - cmd 8'h01 with TXD_VALID=0 -> MISO=1, TXD_READY stays 0.
  - cmd 8'h7E -> MISO=1.
- Abort: SSN rises after 4 of 8 write data beats (WIDTH=1) -> IDLE, no RXD_VALID. Same for a read after 1 of 2 beats (WIDTH=4) -> no TXD_READY, E=0.
- Reset: HRESETn low during RDATA -> next HCLK E=0, MISO=1, TXD_READY=0. Following full write of 8'h5A succeeds.
- WIDTH=2 back-to-back: write 8'hC3 then read 8'h96 with minimum 4-HCLK FT clock phases -> both ACK, correct bytes; no missed or duplicate edges.

Source files
------------

// File: rtl/ft1248_pkg.sv
// Shared FT1248 definitions used by the device responder and the SoCDebug master.
package ft1248_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_TA    = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } ft_state_t;

    localparam logic [7:0] CMD_WRITE    = 8'h00;
    localparam logic [7:0] CMD_READ     = 8'h01;
    localparam logic       ACK          = 1'b0;
    localparam logic       NAK          = 1'b1;
    localparam int         FT_MIN_PHASE = 4;

    function automatic int beats_per_byte(input int width);
        return 8 / width;
    endfunction

endpackage

// File: rtl/ft1248_edge_sync.sv
// Two-flop synchronisers for the FT1248 pins plus CLK/SSN edge detection.
module ft1248_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ft_clk,
    input  logic             i_ft_ssn,
    input  logic [WIDTH-1:0] i_miosio,
    output logic             o_clk_rise,
    output logic             o_clk_fall,
    output logic             o_ssn_fall,
    output logic             o_ssn_rise,
    output logic [WIDTH-1:0] o_miosio
);

    logic             r_clk_s1, r_clk_s2, r_clk_d;
    logic             r_ssn_s1, r_ssn_s2, r_ssn_d;
    logic [WIDTH-1:0] r_mio_s1, r_mio_s2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_d  <= 1'b0;
            r_ssn_s1 <= 1'b1;
            r_ssn_s2 <= 1'b1;
            r_ssn_d  <= 1'b1;
            r_mio_s1 <= '0;
            r_mio_s2 <= '0;
        end else begin
            r_clk_s1 <= i_ft_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_ssn_s1 <= i_ft_ssn;
            r_ssn_s2 <= r_ssn_s1;
            r_ssn_d  <= r_ssn_s2;
            r_mio_s1 <= i_miosio;
            r_mio_s2 <= r_mio_s1;
        end
    end

    // Data shares the clock's sync depth, so it lines up with the detected rise.
    assign o_clk_rise = r_clk_s2 & ~r_clk_d;
    assign o_clk_fall = ~r_clk_s2 & r_clk_d;
    assign o_ssn_fall = ~r_ssn_s2 & r_ssn_d;
    assign o_ssn_rise = r_ssn_s2 & ~r_ssn_d;
    assign o_miosio   = r_mio_s2;

endmodule

// File: rtl/ft1248_device_responder.sv
// Device-side FT1248 responder: decodes master command/data beats and moves
// whole bytes to/from local logic over RXD/TXD valid-ready streams.
module ft1248_device_responder #(
    parameter int FT1248_WIDTH = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    FT_CLK_I,
    input  logic                    FT_SSN_I,
    output logic                    FT_MISO_O,
    input  logic [FT1248_WIDTH-1:0] FT_MIOSIO_I,
    output logic [FT1248_WIDTH-1:0] FT_MIOSIO_O,
    output logic [FT1248_WIDTH-1:0] FT_MIOSIO_E,
    output logic [7:0]              RXD_DATA,
    output logic                    RXD_VALID,
    input  logic                    RXD_READY,
    input  logic [7:0]              TXD_DATA,
    input  logic                    TXD_VALID,
    output logic                    TXD_READY
);
    import ft1248_pkg::*;

    localparam int                    BEATS     = beats_per_byte(FT1248_WIDTH);
    localparam logic [2:0]            LAST_BEAT = 3'(BEATS - 1);
    localparam logic [FT1248_WIDTH-1:0] ALL_ON  = '1;

    logic                    w_clk_rise, w_clk_fall, w_ssn_fall, w_ssn_rise;
    logic [FT1248_WIDTH-1:0] w_mio;
    logic [7:0]              w_wr_byte;

    ft_state_t               r_state, r_state_nxt;
    logic [2:0]              r_cnt, r_cnt_nxt;
    logic [7:0]              r_cmd, r_cmd_nxt;
    logic [7:0]              r_shift, r_shift_nxt;
    logic                    r_miso, r_miso_nxt;
    logic [FT1248_WIDTH-1:0] r_mio_o, r_mio_o_nxt;
    logic [FT1248_WIDTH-1:0] r_mio_e, r_mio_e_nxt;
    logic [7:0]              r_rxd_data, r_rxd_data_nxt;
    logic                    r_rxd_valid, r_rxd_valid_nxt;
    logic                    r_txd_ready, r_txd_ready_nxt;

    ft1248_edge_sync #(.WIDTH(FT1248_WIDTH)) u_sync (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_ft_clk   (FT_CLK_I),
        .i_ft_ssn   (FT_SSN_I),
        .i_miosio   (FT_MIOSIO_I),
        .o_clk_rise (w_clk_rise),
        .o_clk_fall (w_clk_fall),
        .o_ssn_fall (w_ssn_fall),
        .o_ssn_rise (w_ssn_rise),
        .o_miosio   (w_mio)
    );

    assign w_wr_byte = {r_shift[7-FT1248_WIDTH:0], w_mio};

    always_comb begin
        r_state_nxt     = r_state;
        r_cnt_nxt       = r_cnt;
        r_cmd_nxt       = r_cmd;
        r_shift_nxt     = r_shift;
        r_miso_nxt      = r_miso;
        r_mio_o_nxt     = r_mio_o;
        r_mio_e_nxt     = r_mio_e;
        r_rxd_data_nxt  = r_rxd_data;
        r_rxd_valid_nxt = r_rxd_valid & ~RXD_READY;
        r_txd_ready_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                r_miso_nxt  = ~TXD_VALID;
                r_mio_e_nxt = '0;
                if (w_ssn_fall) begin
                    r_state_nxt = ST_CMD;
                    r_cnt_nxt   = '0;
                end
            end
            ST_CMD: begin
                if (w_clk_rise) begin
                    r_cmd_nxt = {r_cmd[7-FT1248_WIDTH:0], w_mio};
                    r_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == LAST_BEAT) begin
                        r_state_nxt = ST_TA;
                        r_cnt_nxt   = '0;
                    end
                end
            end
            ST_TA: begin
                if (w_clk_fall) begin
                    if (r_cmd == CMD_WRITE && !r_rxd_valid) begin
                        r_miso_nxt  = ACK;
                        r_state_nxt = ST_WDATA;
                    end else if (r_cmd == CMD_READ && TXD_VALID) begin
                        r_miso_nxt  = ACK;
                        r_mio_o_nxt = TXD_DATA[7 -: FT1248_WIDTH];
                        r_shift_nxt = TXD_DATA << FT1248_WIDTH;
                        r_mio_e_nxt = ALL_ON;
                        r_state_nxt = ST_RDATA;
                    end else begin
                        r_miso_nxt  = NAK;
                        r_state_nxt = ST_DONE;
                    end
                end
            end
            ST_WDATA: begin
                if (w_clk_rise) begin
                    r_shift_nxt = w_wr_byte;
                    r_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == LAST_BEAT) begin
                        r_rxd_data_nxt  = w_wr_byte;
                        r_rxd_valid_nxt = 1'b1;
                        r_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_RDATA: begin
                if (w_clk_fall) begin
                    r_mio_o_nxt = r_shift[7 -: FT1248_WIDTH];
                    r_shift_nxt = r_shift << FT1248_WIDTH;
                end
                if (w_clk_rise) begin
                    r_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == LAST_BEAT) begin
                        r_txd_ready_nxt = 1'b1;
                        r_mio_e_nxt     = '0;
                        r_state_nxt     = ST_DONE;
                    end
                end
            end
            default: ;
        endcase

        // Master deselect ends any transaction; partial bytes are dropped untouched.
        if (r_state != ST_IDLE && w_ssn_rise) begin
            r_state_nxt     = ST_IDLE;
            r_miso_nxt      = ~TXD_VALID;
            r_mio_o_nxt     = '0;
            r_mio_e_nxt     = '0;
            r_rxd_data_nxt  = r_rxd_data;
            r_rxd_valid_nxt = r_rxd_valid & ~RXD_READY;
            r_txd_ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_miso      <= 1'b1;
            r_mio_o     <= '0;
            r_mio_e     <= '0;
            r_rxd_data  <= '0;
            r_rxd_valid <= 1'b0;
            r_txd_ready <= 1'b0;
        end else begin
            r_state     <= r_state_nxt;
            r_cnt       <= r_cnt_nxt;
            r_miso      <= r_miso_nxt;
            r_mio_o     <= r_mio_o_nxt;
            r_mio_e     <= r_mio_e_nxt;
            r_rxd_data  <= r_rxd_data_nxt;
            r_rxd_valid <= r_rxd_valid_nxt;
            r_txd_ready <= r_txd_ready_nxt;
        end
    end

    always_ff @(posedge HCLK) begin
        r_cmd   <= r_cmd_nxt;
        r_shift <= r_shift_nxt;
    end

    assign FT_MISO_O   = r_miso;
    assign FT_MIOSIO_O = r_mio_o;
    assign FT_MIOSIO_E = r_mio_e;
    assign RXD_DATA    = r_rxd_data;
    assign RXD_VALID   = r_rxd_valid;
    assign TXD_READY   = r_txd_ready;

endmodule

// File: tb/tb_ft1248_device_responder.sv
// Bench driving three responders (widths 1, 2, 4) as an FT1248 master would,
// against a byte-level model of the link's ACK/NAK and stream rules.
module tb_ft1248_device_responder;
    import ft1248_pkg::*;

    logic       hclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ft_clk = 1'b0;
    logic [2:0] ssn = 3'b111;
    logic [3:0] mio_i = 4'h0;

    logic [7:0] txd_data [3];
    logic       txd_valid [3];
    logic       rxd_ready [3];

    logic       miso_w [3];
    logic [3:0] mo_w [3];
    logic [3:0] me_w [3];
    logic [7:0] rxd_data_w [3];
    logic       rxd_valid_w [3];
    logic       txd_ready_w [3];

    logic       mo1, me1;
    logic [1:0] mo2, me2;
    logic [3:0] mo4, me4;

    bit         rx_full [3];
    logic [7:0] rx_byte [3];
    int         pop_cnt [3] = '{0, 0, 0};
    int         vectors = 0;
    int         miscompares = 0;

    always #5 hclk = ~hclk;

    assign mo_w[0] = {3'b000, mo1};
    assign me_w[0] = {3'b000, me1};
    assign mo_w[1] = {2'b00, mo2};
    assign me_w[1] = {2'b00, me2};
    assign mo_w[2] = mo4;
    assign me_w[2] = me4;

    ft1248_device_responder #(.FT1248_WIDTH(1)) u_w1 (
        .HCLK(hclk), .HRESETn(rst_n), .FT_CLK_I(ft_clk), .FT_SSN_I(ssn[0]),
        .FT_MISO_O(miso_w[0]), .FT_MIOSIO_I(mio_i[0:0]), .FT_MIOSIO_O(mo1), .FT_MIOSIO_E(me1),
        .RXD_DATA(rxd_data_w[0]), .RXD_VALID(rxd_valid_w[0]), .RXD_READY(rxd_ready[0]),
        .TXD_DATA(txd_data[0]), .TXD_VALID(txd_valid[0]), .TXD_READY(txd_ready_w[0]));

    ft1248_device_responder #(.FT1248_WIDTH(2)) u_w2 (
        .HCLK(hclk), .HRESETn(rst_n), .FT_CLK_I(ft_clk), .FT_SSN_I(ssn[1]),
        .FT_MISO_O(miso_w[1]), .FT_MIOSIO_I(mio_i[1:0]), .FT_MIOSIO_O(mo2), .FT_MIOSIO_E(me2),
        .RXD_DATA(rxd_data_w[1]), .RXD_VALID(rxd_valid_w[1]), .RXD_READY(rxd_ready[1]),
        .TXD_DATA(txd_data[1]), .TXD_VALID(txd_valid[1]), .TXD_READY(txd_ready_w[1]));

    ft1248_device_responder #(.FT1248_WIDTH(4)) u_w4 (
        .HCLK(hclk), .HRESETn(rst_n), .FT_CLK_I(ft_clk), .FT_SSN_I(ssn[2]),
        .FT_MISO_O(miso_w[2]), .FT_MIOSIO_I(mio_i), .FT_MIOSIO_O(mo4), .FT_MIOSIO_E(me4),
        .RXD_DATA(rxd_data_w[2]), .RXD_VALID(rxd_valid_w[2]), .RXD_READY(rxd_ready[2]),
        .TXD_DATA(txd_data[2]), .TXD_VALID(txd_valid[2]), .TXD_READY(txd_ready_w[2]));

    // Every HCLK cycle with TXD_READY high counts as one pop.
    always @(negedge hclk) begin
        for (int i = 0; i < 3; i++)
            if (txd_ready_w[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // One FT clock beat: data set while low, outputs sampled just before the rise.
    task automatic beat(input int idx, input logic [3:0] bits,
                        output logic [3:0] so, output logic [3:0] se);
        mio_i = bits;
        wait_clks(2);
        so = mo_w[idx];
        se = me_w[idx];
        ft_clk = 1'b1;
        wait_clks(FT_MIN_PHASE);
        ft_clk = 1'b0;
        wait_clks(2);
    endtask

    task automatic xact(input int idx, input logic [7:0] cmd, input logic [7:0] wd,
                        input int stop_after);
        int         w, nb, n, p0, pop_exp;
        logic       ack_exp;
        logic [7:0] sh;
        logic [3:0] so, se, emask;
        w       = 1 << idx;
        nb      = 8 / w;
        emask   = 4'((1 << w) - 1);
        n       = (stop_after < 0) ? nb : stop_after;
        wait_clks(2);
        check("idle_miso", 8'(miso_w[idx]), 8'(!txd_valid[idx]));
        ack_exp = (cmd == CMD_WRITE && !rx_full[idx]) || (cmd == CMD_READ && txd_valid[idx]);
        pop_exp = (ack_exp && cmd == CMD_READ && n == nb) ? 1 : 0;
        p0      = pop_cnt[idx];
        ssn[idx] = 1'b0;
        wait_clks(2);
        sh = cmd;
        for (int b = 0; b < nb; b++) begin
            beat(idx, 4'(sh >> (8 - w)), so, se);
            sh = sh << w;
        end
        wait_clks(2);
        check("ta_ack", 8'(miso_w[idx]), 8'(ack_exp ? ACK : NAK));
        if (ack_exp && cmd == CMD_WRITE) begin
            sh = wd;
            for (int b = 0; b < n; b++) begin
                beat(idx, 4'(sh >> (8 - w)), so, se);
                check("wr_oe", 8'(se), 8'h00);
                sh = sh << w;
            end
            if (n == nb) begin
                rx_full[idx] = 1'b1;
                rx_byte[idx] = wd;
            end
        end else if (ack_exp) begin
            sh = txd_data[idx];
            for (int b = 0; b < n; b++) begin
                beat(idx, 4'(b * 5), so, se);
                check("rd_beat", 8'(so), 8'(4'(sh >> (8 - w))));
                check("rd_oe", 8'(se), 8'(emask));
                sh = sh << w;
            end
            if (n == nb) txd_valid[idx] = 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                beat(idx, 4'hF, so, se);
                check("nak_oe", 8'(se), 8'h00);
            end
        end
        check("pops", 8'(pop_cnt[idx] - p0), 8'(pop_exp));
        ssn[idx] = 1'b1;
        wait_clks(4);
        check("end_oe", 8'(me_w[idx]), 8'h00);
        check("end_miso", 8'(miso_w[idx]), 8'(!txd_valid[idx]));
        check("rxd_valid", 8'(rxd_valid_w[idx]), 8'(rx_full[idx]));
        check("rxd_data", rxd_data_w[idx], rx_byte[idx]);
    endtask

    task automatic drain(input int idx);
        check("rxd_hold", 8'(rxd_valid_w[idx]), 8'(rx_full[idx]));
        rxd_ready[idx] = 1'b1;
        wait_clks(1);
        rxd_ready[idx] = 1'b0;
        rx_full[idx] = 1'b0;
        check("rxd_drained", 8'(rxd_valid_w[idx]), 8'h00);
    endtask

    initial begin
        logic [3:0] so, se;
        int         idx, k, stop;
        logic [7:0] cmd;
        for (int i = 0; i < 3; i++) begin
            txd_data[i]  = 8'h00;
            txd_valid[i] = 1'b0;
            rxd_ready[i] = 1'b0;
            rx_full[i]   = 1'b0;
            rx_byte[i]   = 8'h00;
        end

        rst_n = 1'b0;
        wait_clks(3);
        for (int i = 0; i < 3; i++) begin
            check("rst_miso", 8'(miso_w[i]), 8'h01);
            check("rst_oe", 8'(me_w[i]), 8'h00);
            check("rst_mo", 8'(mo_w[i]), 8'h00);
            check("rst_rxv", 8'(rxd_valid_w[i]), 8'h00);
            check("rst_rxd", rxd_data_w[i], 8'h00);
            check("rst_txr", 8'(txd_ready_w[i]), 8'h00);
        end
        rst_n = 1'b1;
        wait_clks(2);

        // Basic write (width 1) and read (width 4).
        xact(0, CMD_WRITE, 8'hA5, -1);
        wait_clks(6);
        drain(0);
        txd_data[2] = 8'h3C; txd_valid[2] = 1'b1;
        xact(2, CMD_READ, 8'h00, -1);

        // NAK: sink full, no read data, unknown command.
        xact(0, CMD_WRITE, 8'h11, -1);
        xact(0, CMD_WRITE, 8'h22, -1);
        drain(0);
        xact(2, CMD_READ, 8'h00, -1);
        xact(1, 8'h7E, 8'h00, -1);

        // Aborted transfers.
        xact(0, CMD_WRITE, 8'hF0, 4);
        txd_data[2] = 8'h81; txd_valid[2] = 1'b1;
        xact(2, CMD_READ, 8'h00, 1);

        // Reset in the middle of a read, then a clean write.
        txd_data[2] = 8'hE7;
        wait_clks(2);
        ssn[2] = 1'b0;
        wait_clks(2);
        beat(2, 4'h0, so, se);
        beat(2, 4'h1, so, se);
        wait_clks(2);
        check("rst_ta_ack", 8'(miso_w[2]), 8'(ACK));
        k = pop_cnt[2];
        beat(2, 4'h0, so, se);
        check("rst_rd_beat", 8'(so), 8'h0E);
        rst_n = 1'b0;
        ssn[2] = 1'b1;
        wait_clks(1);
        check("midrst_oe", 8'(me_w[2]), 8'h00);
        check("midrst_miso", 8'(miso_w[2]), 8'h01);
        check("midrst_txr", 8'(txd_ready_w[2]), 8'h00);
        wait_clks(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_full[i] = 1'b0;
            rx_byte[i] = 8'h00;
        end
        wait_clks(2);
        check("midrst_pops", 8'(pop_cnt[2] - k), 8'h00);
        xact(0, CMD_WRITE, 8'h5A, -1);

        // Width 2 back-to-back write then read at minimum clock phases.
        xact(1, CMD_WRITE, 8'hC3, -1);
        txd_data[1] = 8'h96; txd_valid[1] = 1'b1;
        xact(1, CMD_READ, 8'h00, -1);

        // Randomised traffic across all three widths.
        for (int t = 0; t < 36; t++) begin
            idx = int'($urandom_range(0, 2));
            if (!txd_valid[idx] && $urandom_range(0, 1) == 1) begin
                txd_data[idx]  = 8'($urandom);
                txd_valid[idx] = 1'b1;
            end
            if (rx_full[idx] && $urandom_range(0, 2) == 0) drain(idx);
            k = int'($urandom_range(0, 7));
            if (k < 3)      cmd = CMD_WRITE;
            else if (k < 6) cmd = CMD_READ;
            else            cmd = 8'($urandom_range(2, 255));
            stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, (8 >> idx) - 1)) : -1;
            xact(idx, cmd, 8'($urandom), stop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
